// File: rtl/pcs_pkg.sv
// Shared PCS definitions used by the 64b/66b scrambler and descrambler.
package pcs_pkg;

    // Block geometry
    localparam int NB_SCRAMBLER   = 58;
    localparam int NB_DATA_CODED  = 66;
    localparam int NB_DATA_TAGGED = 67;
    localparam int NB_SH          = 2;
    localparam int NB_PAYLOAD     = NB_DATA_CODED - NB_SH;

    // Polynomial 1 + x^39 + x^58, taps expressed as (delay - 1)
    localparam int TAP_A = 38;
    localparam int TAP_B = 57;

    // Tap positions inside a state register whose bit NB_SCRAMBLER-1 holds
    // the most recent bit and bit 0 the oldest.
    localparam int STATE_IDX_A = NB_SCRAMBLER - 1 - TAP_A;
    localparam int STATE_IDX_B = NB_SCRAMBLER - 1 - TAP_B;

    // Descrambled idle control block {sync, payload}
    localparam logic [NB_DATA_CODED-1:0] IDLE_BLOCK = 66'h21E00000000000000;

    // Tagged coded block as seen on the RX datapath
    typedef struct packed {
        logic                  tag;
        logic [NB_SH-1:0]      sh;
        logic [NB_PAYLOAD-1:0] payload;
    } tagged_block_t;

endpackage

// File: rtl/descrambler_core.sv
// Combinational, fully unrolled self-synchronising descramble of one
// 64-bit payload. Bits are processed from 63 down to 0; the received
// (scrambled) bit is what enters the state, so any seed converges after
// NB_SCRAMBLER received bits.
module descrambler_core
    import pcs_pkg::*;
(
    input  logic [NB_SCRAMBLER-1:0] i_state,
    input  logic [NB_PAYLOAD-1:0]   i_data,
    output logic [NB_PAYLOAD-1:0]   o_data,
    output logic [NB_SCRAMBLER-1:0] o_state
);

    logic [NB_SCRAMBLER-1:0] w_shift;

    // Walk the payload MSB first, shifting each received bit into the state
    always_comb begin
        w_shift = i_state;
        o_data  = '0;
        for (int i = NB_PAYLOAD - 1; i >= 0; i--) begin
            o_data[i] = i_data[i] ^ w_shift[STATE_IDX_A] ^ w_shift[STATE_IDX_B];
            w_shift   = {i_data[i], w_shift[NB_SCRAMBLER-1:1]};
        end
        o_state = w_shift;
    end

endmodule

// File: rtl/descrambler.sv
// RX 64b/66b descrambler. Descrambles the payload of untagged, non-bypass
// blocks, passes everything else through, tracks convergence and counts
// corrupted blocks while the idle test pattern is expected.
module descrambler
    import pcs_pkg::*;
#(
    parameter logic [NB_SCRAMBLER-1:0] SEED        = '0,
    parameter int                      LOCK_BLOCKS = 1,
    parameter int                      NB_ERR_CNT  = 16
)(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_valid,
    input  logic                      i_bypass,
    input  logic                      i_idle_pattern_mode,
    input  logic                      i_clear_err,
    input  logic [NB_DATA_TAGGED-1:0] i_data,
    output logic [NB_DATA_TAGGED-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_locked,
    output logic                      o_idle_error,
    output logic [NB_ERR_CNT-1:0]     o_idle_err_count
);

    // Lock counter sized to hold LOCK_BLOCKS
    localparam int               NB_LOCK  = (LOCK_BLOCKS < 1) ? 1 : $clog2(LOCK_BLOCKS + 1);
    localparam logic [NB_LOCK-1:0] LOCK_MAX = NB_LOCK'(LOCK_BLOCKS);

    // Datapath handshake: a block is consumed on any cycle with
    // i_enable & i_valid; there is no backpressure. o_valid marks the
    // cycle after a consumed block, when o_data carries its result.

    tagged_block_t           w_in;
    logic                    w_adv;
    logic [NB_PAYLOAD-1:0]   w_payload;
    logic [NB_SCRAMBLER-1:0] w_state_next;
    logic                    w_idle_mismatch;
    logic                    w_err;
    logic [NB_LOCK-1:0]      w_lock_cnt_next;
    logic                    w_err_cnt_full;

    logic [NB_SCRAMBLER-1:0]   r_state;
    logic [NB_DATA_TAGGED-1:0] r_data;
    logic                      r_valid;
    logic [NB_LOCK-1:0]        r_lock_cnt;
    logic                      r_locked;
    logic                      r_idle_error;
    logic [NB_ERR_CNT-1:0]     r_err_cnt;

    assign w_in = i_data;

    // Tagged blocks (alignment markers) are never scrambled: treat as bypass
    assign w_adv = i_enable & i_valid & ~i_bypass & ~w_in.tag;

    descrambler_core u_core (
        .i_state (r_state),
        .i_data  (w_in.payload),
        .o_data  (w_payload),
        .o_state (w_state_next)
    );

    assign w_idle_mismatch = ({w_in.sh, w_payload} != IDLE_BLOCK);
    // Only judge idle blocks once the state has converged
    assign w_err           = w_adv & i_idle_pattern_mode & r_locked & w_idle_mismatch;
    assign w_lock_cnt_next = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + 1'b1;
    assign w_err_cnt_full  = &r_err_cnt;

    // Descrambler state: advances only when a payload is actually descrambled
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= SEED;
        end else if (w_adv) begin
            r_state <= w_state_next;
        end
    end

    // Output register: descrambled or passed-through block, one cycle latency
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_enable) begin
            r_valid <= i_valid;
            if (w_adv) begin
                r_data <= {w_in.tag, w_in.sh, w_payload};
            end else if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    // Lock tracking: counts descrambled blocks, saturating; only reset clears it
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_adv) begin
            r_lock_cnt <= w_lock_cnt_next;
            r_locked   <= (w_lock_cnt_next == LOCK_MAX);
        end
    end

    // Idle-pattern error pulse and saturating counter; clear beats increment
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_idle_error <= 1'b0;
            r_err_cnt    <= '0;
        end else if (i_enable) begin
            r_idle_error <= w_err;
            if (i_clear_err) begin
                r_err_cnt <= '0;
            end else if (w_err && !w_err_cnt_full) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_data           = r_data;
    assign o_valid          = r_valid;
    assign o_locked         = r_locked;
    assign o_idle_error     = r_idle_error;
    assign o_idle_err_count = r_err_cnt;

endmodule
